// File: rtl/board_io_pkg.sv
// Shared types and default constants for the DE10-Lite board input path.
package board_io_pkg;

    // Per-key debounce state
    typedef enum logic [1:0] {
        StReleased    = 2'd0,
        StPressPend   = 2'd1,
        StPressed     = 2'd2,
        StReleasePend = 2'd3
    } deb_state_e;

    // 10 ms of stable level at 50 MHz
    localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;
    // One run-mode step per second at 50 MHz
    localparam int unsigned RUN_1HZ_50MHZ       = 50000000;

    // Auto-repeat timing: 0.5 s hold before repeating, then 10 steps per second
    localparam int unsigned HOLD_CYCLES_DEFAULT   = 25000000;
    localparam int unsigned REPEAT_CYCLES_DEFAULT = 5000000;

    // Counter width for a 0..n-1 counter, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces one synchronized, active-high key level into a clean level plus
// one-cycle press and release pulses.
module key_debounce
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, release_q;

    // State, stability counter and registered edge pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StReleased;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= (state_q == StPressPend) && (state_d == StPressed);
            release_q <= (state_q == StReleasePend) && (state_d == StReleased);
        end
    end

    // Next state: a level change must hold for DEBOUNCE_CYCLES samples in a
    // pending state; any reversion returns to the stable state silently
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            StReleased: begin
                if (key_in) state_d = StPressPend;
            end
            StPressPend: begin
                if (!key_in) begin
                    state_d = StReleased;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StPressed;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPressed: begin
                if (!key_in) state_d = StReleasePend;
            end
            StReleasePend: begin
                if (key_in) begin
                    state_d = StPressed;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StReleased;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StReleased;
        endcase
    end

    // Outputs: level is held through the release-pending window
    always_comb begin
        level         = (state_q == StPressed) || (state_q == StReleasePend);
        press_pulse   = press_q;
        release_pulse = release_q;
    end

endmodule

// File: rtl/board_input_ctrl.sv
// Board-side input conditioner: synchronizes SW/KEY, debounces the keys and
// generates the CPU step enable (single-step on KEY[0] or free-run on SW[9]).
// KEY[1] press doubles as a CPU reset request and has priority over stepping.
// Optional: define BOARD_INPUT_AUTOREPEAT_EN for KEY[0] hold-to-repeat in
// step mode. NUM_KEYS must be at least 2.
module board_input_ctrl
    import board_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int unsigned RUN_DIV         = RUN_1HZ_50MHZ,
    parameter int unsigned NUM_KEYS        = 2
) (
    input  logic                MAX10_CLK1_50,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [9:0]          SW,
    output logic [9:0]          sw_sync,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                run_mode,
    output logic                step_en,
    output logic                cpu_rst_req
);

    localparam int unsigned      DIV_W    = cnt_width(RUN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic [NUM_KEYS-1:0] key_sync_q [SYNC_STAGES];
    logic [9:0]          sw_sync_q  [SYNC_STAGES];
    logic [NUM_KEYS-1:0] key_active;
    logic [NUM_KEYS-1:0] press_raw;
    logic [NUM_KEYS-1:0] release_raw;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                run_prev_q;
    logic                repeat_pulse;

    // Synchronizer chains; keys idle high (released)
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                key_sync_q[i] <= '1;
                sw_sync_q[i]  <= '0;
            end
        end else begin
            key_sync_q[0] <= KEY;
            sw_sync_q[0]  <= SW;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                key_sync_q[i] <= key_sync_q[i-1];
                sw_sync_q[i]  <= sw_sync_q[i-1];
            end
        end
    end

    // Keys are active-low at the pin
    always_comb begin
        key_active = ~key_sync_q[SYNC_STAGES-1];
        sw_sync    = sw_sync_q[SYNC_STAGES-1];
        run_mode   = sw_sync[9];
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk          (MAX10_CLK1_50),
            .reset        (reset),
            .key_in       (key_active[k]),
            .level        (key_level[k]),
            .press_pulse  (press_raw[k]),
            .release_pulse(release_raw[k])
        );
    end

    // Pulses are suppressed in the reset cycle itself, before state clears
    always_comb begin
        key_press   = press_raw & {NUM_KEYS{~reset}};
        key_release = release_raw & {NUM_KEYS{~reset}};
        cpu_rst_req = press_raw[1] & ~reset;
    end

    // Run divider: held at 0 outside run mode and on the entry cycle, so the
    // first terminal count lands RUN_DIV cycles after run_mode rises
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            div_q      <= '0;
            run_prev_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            run_prev_q <= run_mode;
        end
    end

    // Divider next value; CPU reset request restarts the period
    always_comb begin
        div_d = '0;
        if (run_mode && run_prev_q && !cpu_rst_req) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

`ifdef BOARD_INPUT_AUTOREPEAT_EN
    localparam int unsigned      HOLD_CYCLES   = HOLD_CYCLES_DEFAULT;
    localparam int unsigned      REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT;
    localparam int unsigned      HOLD_W        = cnt_width(HOLD_CYCLES);
    localparam int unsigned      REP_W         = cnt_width(REPEAT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST     = REP_W'(REPEAT_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              repeating_q, repeating_d;

    // Hold/repeat counters for KEY[0]
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            hold_q      <= '0;
            rep_q       <= '0;
            repeating_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            rep_q       <= rep_d;
            repeating_q <= repeating_d;
        end
    end

    // Count the hold time, then emit a pulse each repeat period until release
    always_comb begin
        hold_d       = hold_q;
        rep_d        = rep_q;
        repeating_d  = repeating_q;
        repeat_pulse = 1'b0;
        if (!key_level[0] || run_mode || cpu_rst_req) begin
            hold_d      = '0;
            rep_d       = '0;
            repeating_d = 1'b0;
        end else if (!repeating_q) begin
            if (hold_q == HOLD_LAST) begin
                hold_d      = '0;
                repeating_d = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end else if (rep_q == REP_LAST) begin
            rep_d        = '0;
            repeat_pulse = 1'b1;
        end else begin
            rep_d = rep_q + 1'b1;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

    // Step enable: CPU reset request wins over both run and step sources
    always_comb begin
        step_en = 1'b0;
        if (!reset && !cpu_rst_req) begin
            if (run_mode) begin
                step_en = (div_q == DIV_LAST);
            end else begin
                step_en = press_raw[0] | repeat_pulse;
            end
        end
    end

endmodule

// File: doc/board_input_ctrl.md
Name: board_input_ctrl

Overview:
- Board-side input conditioner for the multi-cycle MIPS32 top level.
- Synchronizes the raw DE10-Lite switches and keys, and debounces the keys into clean level, press and release signals.
- Generates the CPU clock-enable (`step_en`): single-step on KEY[0] presses, or free-run at a divided rate selected by SW[9].
- Sits between the board pins and the CPU/display logic; it is the input-side counterpart of the HEX/LEDR output path.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth for KEY and SW (min 2).
- DEBOUNCE_CYCLES, 500000, stable cycles required before a key level change is accepted (10 ms at 50 MHz).
- RUN_DIV, 50000000, run-mode `step_en` period in clock cycles (min 2).
- NUM_KEYS, 2, number of key inputs debounced.

Ports:
- MAX10_CLK1_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- KEY  in  NUM_KEYS  raw pushbuttons, active-low, asynchronous.
- SW  in  10  raw slide switches, asynchronous.
- sw_sync  out  10  synchronized switches.
- key_level  out  NUM_KEYS  debounced key state, active-high (1 = pressed).
- key_press  out  NUM_KEYS  one-cycle pulse on accepted press.
- key_release  out  NUM_KEYS  one-cycle pulse on accepted release.
- run_mode  out  1  equals sw_sync[9]; 1 = free-run, 0 = single-step.
- step_en  out  1  one-cycle CPU advance enable.
- cpu_rst_req  out  1  one-cycle pulse, equals key_press[1].

Behaviour:
- Single clock domain. Reset is synchronous and active-high: MAX10_CLK1_50 rising edge with reset=1 initializes everything.
- Reset values:
  - KEY synchronizer flops = 1 (released); SW synchronizer flops = 0.
  - All outputs = 0; all debounce FSMs = RELEASED; all counters = 0.
- Synchronization:
  - KEY and SW each pass through SYNC_STAGES flops.
  - sw_sync lags SW by SYNC_STAGES cycles.
  - The key path inverts after synchronization (pressed = 1).
- Per-key debounce FSM, states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND:
  - RELEASED: synced key = 1 → PRESS_PEND, counter cleared.
  - PRESS_PEND:
    - Synced key = 1: counter increments.
    - Synced key = 0: back to RELEASED, counter cleared, no pulse.
    - Counter = DEBOUNCE_CYCLES-1 with key still 1: → PRESSED; key_press pulses next cycle; key_level=1.
  - PRESSED / RELEASE_PEND mirror the above with key = 0; key_release pulses when the release is accepted.
  - Glitch shorter than DEBOUNCE_CYCLES: no output change.
  - Press latency from stable pin change = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- key_press and key_release are never high in the same cycle for one key. Keys are independent.
- step_en, step mode (run_mode=0):
  - step_en = key_press[0]: exactly one pulse per accepted press.
  - The run divider is held at 0.
- step_en, run mode (run_mode=1):
  - Divider counts 0..RUN_DIV-1; step_en=1 only at terminal count, then wraps to 0.
  - key_press[0] is ignored for stepping.
  - On entry to run mode the divider starts from 0, so the first pulse comes RUN_DIV cycles after run_mode rises.
- Leaving run mode mid-count: divider cleared the same cycle; no stray pulse.
- cpu_rst_req=1 in a cycle:
  - step_en is forced 0 that cycle.
  - The divider is cleared.
  - This priority applies even if the terminal count or key_press[0] coincides.
- Reset mid-debounce or mid-count: all state returns to reset values; no pulses emitted in the reset cycle or the cycle after.
- Counter widths: $clog2 of the respective parameter. No overflow: counters never exceed their terminal value.

Optional Feature:
- Macro: BOARD_INPUT_AUTOREPEAT_EN.
- Defined, step mode only:
  - Holding KEY[0] in PRESSED for HOLD_CYCLES (localparam = 25000000) starts auto-repeat.
  - Auto-repeat emits step_en every REPEAT_CYCLES (localparam = 5000000) until release.
  - The repeat counter clears on release or on cpu_rst_req.
- Undefined: no repeat logic is instantiated; step_en behaves strictly as above.

Decomposition:
- Shared package board_io_pkg holds:
  - The debounce state enum (RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND).
  - Default constants DEBOUNCE_10MS_50MHZ and RUN_1HZ_50MHZ.
  - The HOLD/REPEAT localparam defaults.
- One sub-module, key_debounce, handles one key:
  - Inputs: synced active-high level.
  - Outputs: level, press pulse, release pulse.
  - Instantiated NUM_KEYS times via generate.
- The synchronizer and step/run logic live in the parent.

Test Plan:
Bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RUN_DIV=8.
- Clean press: KEY[0] 1→0, held 10 cycles → key_press[0] one pulse at cycle 7, key_level[0]=1, step_en one pulse same cycle.
- Bounce: KEY[0] low 3 cycles, high 1, low 3, high → no key_press, key_level stays 0.
- Run mode: SW[9]=1 for 40 cycles → run_mode after 2 cycles, step_en pulses every 8 cycles (4 pulses); KEY[0] presses produce no extra pulses.
- Priority: in run mode, KEY[1] press accepted on the divider terminal-count cycle → cpu_rst_req=1, step_en=0, next pulse 8 cycles later.
- Reset mid-debounce: KEY[0] low 3 cycles, reset 1 cycle, key held → press accepted 4+3 cycles after reset deasserts, outputs 0 during reset.
- With BOARD_INPUT_AUTOREPEAT_EN and bench HOLD=16, REPEAT=4: KEY[0] held 40 cycles → initial pulse, then pulses every 4 cycles after hold, none after release.
